// File: rtl/axis_matmul_pkg.sv
// Shared types, field layout and beat packing for the matmul AXI-Stream driver.
package axis_matmul_pkg;

    localparam int unsigned OPW    = 4;
    localparam int unsigned RESW   = 16;
    localparam int unsigned BEAT_W = 32;

    localparam int unsigned A0_LSB = 0;
    localparam int unsigned A1_LSB = 8;
    localparam int unsigned B0_LSB = 16;
    localparam int unsigned B1_LSB = 24;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        SEND    = 2'd1,
        COLLECT = 2'd2
    } state_e;

    // Each operand sits in the low nibble of its own byte lane; upper nibbles are zero.
    function automatic logic [BEAT_W-1:0] pack_beat(input logic [OPW-1:0] a0,
                                                     input logic [OPW-1:0] a1,
                                                     input logic [OPW-1:0] b0,
                                                     input logic [OPW-1:0] b1);
        logic [BEAT_W-1:0] beat;
        beat                  = '0;
        beat[A0_LSB +: OPW]   = a0;
        beat[A1_LSB +: OPW]   = a1;
        beat[B0_LSB +: OPW]   = b0;
        beat[B1_LSB +: OPW]   = b1;
        return beat;
    endfunction

endpackage

// File: rtl/axis_matmul_driver_if.sv
// Load port, operand stream, result stream and host result port of the matmul driver.
// master: the driver itself; slave: the surrounding environment.
interface axis_matmul_driver_if;
    import axis_matmul_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [OPW-1:0]    ld_a0;
    logic [OPW-1:0]    ld_a1;
    logic [OPW-1:0]    ld_b0;
    logic [OPW-1:0]    ld_b1;
    logic              ld_last;

    logic              m_axis_tvalid;
    logic [BEAT_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    logic              s_axis_tvalid;
    logic [BEAT_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              s_axis_tready;

    logic              res_valid;
    logic [RESW-1:0]   res_c0;
    logic [RESW-1:0]   res_c1;
    logic              res_ready;

    modport master (
        input  ld_valid, ld_a0, ld_a1, ld_b0, ld_b1, ld_last,
        output ld_ready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        input  m_axis_tready,
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready,
        output res_valid, res_c0, res_c1,
        input  res_ready
    );

    modport slave (
        output ld_valid, ld_a0, ld_a1, ld_b0, ld_b1, ld_last,
        input  ld_ready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        output m_axis_tready,
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready,
        input  res_valid, res_c0, res_c1,
        output res_ready
    );

endinterface

// File: rtl/axis_beat_buf.sv
// DEPTH x 32-bit FIFO holding one job of packed operand beats.
// Pointers wrap modulo DEPTH; clr empties the buffer synchronously.
module axis_beat_buf
    import axis_matmul_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BEAT_W-1:0] rd_data,
    output logic [CntW-1:0]   count,
    output logic              full,
    output logic              empty
);

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_wr, do_rd;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Storage array: written on accepted loads, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CntW'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/axis_matmul_driver.sv
// Master-side driver for the 2x2 matmul AXI-Stream wrapper: buffers a job of operand
// tuples, streams it as one packet, then passes the result beats through to the host.
// Optional COLLECT watchdog: define AXIS_DRV_TIMEOUT_EN.
module axis_matmul_driver
    import axis_matmul_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_matmul_driver_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    state_e            state_q, state_d;
    logic              tvalid_q, tvalid_d;
    logic [BEAT_W-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d;

    logic              buf_clr, buf_wr, buf_rd;
    logic [BEAT_W-1:0] buf_rd_data;
    logic [CntW-1:0]   buf_count;
    logic              buf_full, buf_empty;

    logic              ld_ready;
    logic              ld_accept;
    logic              m_hs;
    logic              s_hs;
    logic              in_collect;
    logic              to_expired;

    axis_beat_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (pack_beat(bus.ld_a0, bus.ld_a1, bus.ld_b0, bus.ld_b1)),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign ld_ready   = (state_q == LOAD) && !buf_full;
    assign ld_accept  = bus.ld_valid && ld_ready;
    assign m_hs       = tvalid_q && bus.m_axis_tready;
    assign in_collect = (state_q == COLLECT);
    assign s_hs       = in_collect && bus.s_axis_tvalid && bus.res_ready;

    assign bus.ld_ready      = ld_ready;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tlast  = tlast_q;

    // Result path is a straight pass-through while collecting, gated off otherwise.
    assign bus.s_axis_tready = in_collect && bus.res_ready;
    assign bus.res_valid     = in_collect && bus.s_axis_tvalid;
    assign bus.res_c0        = in_collect ? bus.s_axis_tdata[RESW-1:0] : '0;
    assign bus.res_c1        = in_collect ? bus.s_axis_tdata[2*RESW-1:RESW] : '0;

    assign busy = (state_q != LOAD) || !buf_empty;

`ifdef AXIS_DRV_TIMEOUT_EN
    localparam int unsigned ToW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           err_q, err_d;

    assign to_expired  = in_collect && !s_hs && (to_cnt_q == ToW'(TO_CYCLES - 1));
    assign err_timeout = err_q;

    // Watchdog counts idle COLLECT cycles; any result handshake restarts it.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!in_collect || s_hs || to_expired) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    // Timeout flag is sticky until the host starts a new job.
    always_comb begin
        err_d = err_q;
        if (ld_accept) begin
            err_d = 1'b0;
        end else if (to_expired) begin
            err_d = 1'b1;
        end
    end

    // Watchdog state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    logic unused_to_cycles;

    assign unused_to_cycles = ^TO_CYCLES;
    assign to_expired       = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    // FSM and output-beat registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    // Next-state, buffer control and operand-beat staging.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        buf_wr   = 1'b0;
        buf_rd   = 1'b0;
        buf_clr  = 1'b0;
        done     = 1'b0;

        case (state_q)
            LOAD: begin
                if (ld_accept) begin
                    buf_wr = 1'b1;
                    // Beat number DEPTH closes the job regardless of ld_last.
                    if (bus.ld_last || (buf_count == CntW'(DEPTH - 1))) begin
                        state_d = SEND;
                    end
                end
            end

            SEND: begin
                if (m_hs && tlast_q) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = COLLECT;
                end else if (!tvalid_q || m_hs) begin
                    // Refill the output stage in the handshake cycle so beats stay back-to-back.
                    if (!buf_empty) begin
                        buf_rd   = 1'b1;
                        tvalid_d = 1'b1;
                        tdata_d  = buf_rd_data;
                        tlast_d  = (buf_count == CntW'(1));
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end
            end

            COLLECT: begin
                if (s_hs && bus.s_axis_tlast) begin
                    done    = 1'b1;
                    buf_clr = 1'b1;
                    state_d = LOAD;
                end else if (to_expired) begin
                    buf_clr = 1'b1;
                    state_d = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_matmul_driver.sv
// Directed self-checking bench for axis_matmul_driver (DEPTH=4, TO_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_matmul_driver;
    import axis_matmul_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic err_timeout;

    int   n_chk;
    int   n_pass;

    logic [31:0] exp_beats [4];

    axis_matmul_driver_if bus_if ();

    axis_matmul_driver #(
        .DEPTH     (4),
        .TO_CYCLES (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one tuple and hold it until accepted (bounded).
    task automatic load_tuple(input logic [3:0] a0, input logic [3:0] a1,
                              input logic [3:0] b0, input logic [3:0] b1, input logic last);
        int waited;
        @(negedge clk);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_a0    = a0;
        bus_if.ld_a1    = a1;
        bus_if.ld_b0    = b0;
        bus_if.ld_b1    = b1;
        bus_if.ld_last  = last;
        waited = 0;
        while (!bus_if.ld_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("ld_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus_if.ld_valid = 1'b0;
        bus_if.ld_last  = 1'b0;
    endtask

    // Accept n operand beats, optionally toggling tready, and compare to exp_beats.
    task automatic send_phase(input int n, input logic toggle);
        int          cnt;
        int          cyc;
        logic        stalled;
        logic [31:0] held;
        cnt     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (cnt < n && cyc < 200) begin
            @(negedge clk);
            bus_if.m_axis_tready = toggle ? cyc[0] : 1'b1;
            if (bus_if.m_axis_tvalid) begin
                if (stalled) check("tdata_hold", bus_if.m_axis_tdata, held);
                if (bus_if.m_axis_tready) begin
                    check($sformatf("beat%0d_data", cnt), bus_if.m_axis_tdata, exp_beats[cnt]);
                    check($sformatf("beat%0d_last", cnt), 32'(bus_if.m_axis_tlast),
                          32'(cnt == n - 1));
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus_if.m_axis_tdata;
                end
            end
            cyc++;
        end
        if (cnt < n) check("send_timeout", 32'(cnt), 32'(n));
        @(negedge clk);
        check("tvalid_drop_after_last", 32'(bus_if.m_axis_tvalid), 32'd0);
        bus_if.m_axis_tready = 1'b0;
    endtask

    // Offer one result beat with res_ready high and check the pass-through.
    task automatic give_result(input logic [31:0] data, input logic last);
        @(negedge clk);
        bus_if.s_axis_tvalid = 1'b1;
        bus_if.s_axis_tdata  = data;
        bus_if.s_axis_tlast  = last;
        bus_if.res_ready     = 1'b1;
        #1;
        check("res_valid", 32'(bus_if.res_valid), 32'd1);
        check("s_tready", 32'(bus_if.s_axis_tready), 32'd1);
        check("res_c0", 32'(bus_if.res_c0), {16'd0, data[15:0]});
        check("res_c1", 32'(bus_if.res_c1), {16'd0, data[31:16]});
        check("done_pulse", 32'(done), 32'(last));
        @(negedge clk);
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tlast  = 1'b0;
        #1;
        check("done_low_after", 32'(done), 32'd0);
    endtask

    initial begin
        n_chk                = 0;
        n_pass               = 0;
        rst                  = 1'b0;
        bus_if.ld_valid      = 1'b0;
        bus_if.ld_a0         = '0;
        bus_if.ld_a1         = '0;
        bus_if.ld_b0         = '0;
        bus_if.ld_b1         = '0;
        bus_if.ld_last       = 1'b0;
        bus_if.m_axis_tready = 1'b0;
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tdata  = '0;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.res_ready     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tvalid", 32'(bus_if.m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(bus_if.m_axis_tlast), 32'd0);
        check("rst_s_tready", 32'(bus_if.s_axis_tready), 32'd0);
        check("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // T1: single tuple job
        exp_beats[0] = 32'h0501_0203;
        load_tuple(4'd3, 4'd2, 4'd1, 4'd5, 1'b1);
        check("t1_ld_ready_low", 32'(bus_if.ld_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        send_phase(1, 1'b0);
        give_result(32'h000D_0005, 1'b1);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_ld_ready", 32'(bus_if.ld_ready), 32'd1);

        // T2: three tuples, tready toggling
        exp_beats[0] = 32'h0403_0201;
        exp_beats[1] = 32'h0807_0605;
        exp_beats[2] = 32'h0C0B_0A09;
        load_tuple(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        load_tuple(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
        load_tuple(4'd9, 4'd10, 4'd11, 4'd12, 1'b1);
        send_phase(3, 1'b1);
        give_result(32'h1234_5678, 1'b1);

        // T3: DEPTH tuples without ld_last
        exp_beats[0] = 32'h0101_0101;
        exp_beats[1] = 32'h0202_0202;
        exp_beats[2] = 32'h0303_0303;
        exp_beats[3] = 32'h0404_0404;
        load_tuple(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        load_tuple(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
        load_tuple(4'd3, 4'd3, 4'd3, 4'd3, 1'b0);
        load_tuple(4'd4, 4'd4, 4'd4, 4'd4, 1'b0);
        check("t3_ld_ready_low", 32'(bus_if.ld_ready), 32'd0);
        send_phase(4, 1'b0);
        give_result(32'hABCD_0001, 1'b1);

        // T4: results offered during SEND, host stalls 5 cycles in COLLECT
        exp_beats[0] = 32'h0000_0F00;
        exp_beats[1] = 32'h0E00_0000;
        load_tuple(4'd0, 4'd15, 4'd0, 4'd0, 1'b0);
        load_tuple(4'd0, 4'd0, 4'd0, 4'd14, 1'b1);
        bus_if.s_axis_tvalid = 1'b1;
        bus_if.s_axis_tdata  = 32'h0002_0001;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.res_ready     = 1'b1;
        @(negedge clk);
        check("t4_send_s_tready", 32'(bus_if.s_axis_tready), 32'd0);
        check("t4_send_res_valid", 32'(bus_if.res_valid), 32'd0);
        bus_if.res_ready = 1'b0;
        send_phase(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_s_tready", 32'(bus_if.s_axis_tready), 32'd0);
            check("t4_stall_res_c0", 32'(bus_if.res_c0), 32'd1);
            @(negedge clk);
        end
        give_result(32'h0002_0001, 1'b0);
        give_result(32'h0004_0003, 1'b1);

        // T5: asynchronous reset mid-SEND after first beat accepted
        load_tuple(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        load_tuple(4'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        bus_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 10 && !bus_if.m_axis_tvalid; i++) @(negedge clk);
        check("t5_beat1_data", bus_if.m_axis_tdata, 32'h0000_0001);
        @(negedge clk);
        bus_if.m_axis_tready = 1'b0;
        check("t5_beat2_pending", 32'(bus_if.m_axis_tvalid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_tvalid", 32'(bus_if.m_axis_tvalid), 32'd0);
        check("t5_async_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_post_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        check("t5_post_busy", 32'(busy), 32'd0);

`ifdef AXIS_DRV_TIMEOUT_EN
        // T6: no result returned, watchdog fires
        begin
            logic saw_done;
            int   cyc;
            saw_done = 1'b0;
            exp_beats[0] = 32'h0000_0007;
            load_tuple(4'd7, 4'd0, 4'd0, 4'd0, 1'b1);
            send_phase(1, 1'b0);
            cyc = 0;
            while (!err_timeout && cyc < 40) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
                cyc++;
            end
            check("t6_err", 32'(err_timeout), 32'd1);
            check("t6_no_done", 32'(saw_done), 32'd0);
            check("t6_ld_ready", 32'(bus_if.ld_ready), 32'd1);
            check("t6_busy", 32'(busy), 32'd0);
            load_tuple(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
            check("t6_err_cleared", 32'(err_timeout), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
